pulse_gen: RTL and testbench
============================

# pulse_gen

Transmit-side counterpart to the rising-edge detector: emits a programmable train of clean, registered pulses on `pulse_out` for downstream logic that counts rising edges. A one-cycle `start` strobe latches the pulse count and the high and low widths. The block then runs a three-state FSM (IDLE/HIGH/LOW) driven by internal down-counters and reports `busy`, `done` and a count of pulses sent.

## Interface
- `WIDTH`, 8: bit width of the high/low phase length inputs and internal phase counter
- `COUNT_WIDTH`, 8: bit width of the pulse count input and `pulses_sent`
- `clock`  input  1  sole clock; all state updates on posedge
- `reset`  input  1  synchronous, active-high; overrides all other inputs
- `start`  input  1  one-cycle strobe; accepted only in IDLE
- `abort`  input  1  stops an active train at the next edge
- `high_len`  input  WIDTH  high-phase length in cycles; sampled on accepted start
- `low_len`  input  WIDTH  low-phase length in cycles; sampled on accepted start
- `num_pulses`  input  COUNT_WIDTH  number of pulses; sampled on accepted start
- `pulse_out`  output  1  registered pulse waveform
- `busy`  output  1  high while in HIGH or LOW
- `done`  output  1  one-cycle strobe on normal train completion
- `pulses_sent`  output  COUNT_WIDTH  rising edges emitted in the current/last train

## Operation
- Reset: state=IDLE; `pulse_out`=0, `busy`=0, `done`=0, `pulses_sent`=0; latched config cleared.
- IDLE, `start`=1, `abort`=0, `num_pulses`≠0, `high_len`≠0 (accepted start):
  - latch `high_len`, `num_pulses`, and `low_len` (a value of 0 is latched as 1, so consecutive pulses always have a low gap);
  - `pulses_sent`←1; go to HIGH.
- IDLE, `start` with `num_pulses`=0 or `high_len`=0: ignored; no `done`, `pulses_sent` unchanged.
- HIGH: `pulse_out`=1 for exactly high_len cycles. At phase end:
  - remaining pulses >0 → go to LOW;
  - last pulse → go to IDLE and assert `done` for 1 cycle.
- LOW: `pulse_out`=0 for exactly low_len cycles, then go to HIGH and increment `pulses_sent`.
- `start` while busy: ignored; the latched config is not disturbed.
- `abort` while busy: next edge goes to IDLE with `pulse_out`=0; `done` is not asserted; `pulses_sent` holds its value.
- `abort` and `start` together in IDLE: abort wins, start is ignored.
- `pulses_sent` holds after completion or abort until the next accepted start or reset.
- Counters saturate nowhere; the max width 2^WIDTH−1 is supported without wrap. Input changes while busy have no effect.

## Timing
- `start` is sampled at edge t. `pulse_out`=1 during cycles t+1 … t+high_len.
- Train duration: N·high_len + (N−1)·low_len cycles, with low_len after the 0→1 substitution. There is no trailing low phase.
- `busy` equals the state: it rises with the first `pulse_out` rise and falls in the same cycle as the final `pulse_out` fall.
- `done`=1 in the first cycle after the last high cycle, concurrent with `busy`=0.
- Back-to-back trains: a `start` in the cycle where `done`=1 is accepted. The next pulse rises one cycle later, so there is a minimum 1-cycle low gap.
- `reset` mid-train: at the next edge all outputs go to 0. No `done`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then start with high_len=3, low_len=2, num_pulses=4 → `pulse_out` pattern 111 00 111 00 111 00 111. Train is 18 cycles long; `done` is a single pulse at cycle 19 after start; `pulses_sent`=4. An edge detector on `pulse_out` counts 4.
- high_len=1, low_len=0, num_pulses=3 → 1 0 1 0 1, i.e. low_len is treated as 1; `pulses_sent`=3; `done` once.
- Start with num_pulses=0, and separately with high_len=0 → `busy` stays 0, no `done`, `pulses_sent` unchanged.
- Train with high_len=5, low_len=5, num_pulses=10; assert `abort` during the 3rd low phase → `pulse_out`=0 and `busy`=0 next cycle, no `done`, `pulses_sent`=3. A `start` during the train (before the abort) is ignored.
- Assert `start` in the `done` cycle with new config (2, 1, 2) → the second train begins 1 cycle later with the new widths. Assert `reset` mid-train → all outputs 0 next edge.
- WIDTH=4: high_len=15, low_len=15, num_pulses=2 → exactly 15 high, 15 low, 15 high cycles; no counter wrap.

Source files
------------

// File: rtl/pulse_gen.sv
// Programmable pulse-train generator: a start strobe latches count and phase
// widths, then an IDLE/HIGH/LOW FSM emits registered pulses on pulse_out.
module pulse_gen #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [WIDTH-1:0]       high_len,
  input  logic [WIDTH-1:0]       low_len,
  input  logic [COUNT_WIDTH-1:0] num_pulses,
  output logic                   pulse_out,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] pulses_sent
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t                 state;
  logic [WIDTH-1:0]       high_lat;
  logic [WIDTH-1:0]       low_lat;
  logic [COUNT_WIDTH-1:0] num_lat;
  logic [WIDTH-1:0]       phase_cnt;
  logic                   start_ok;
  logic                   phase_end;

  // phase_cnt holds the cycles remaining in the current phase, including this one
  assign start_ok  = start && !abort && (num_pulses != '0) && (high_len != '0);
  assign phase_end = (phase_cnt == WIDTH'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      high_lat    <= '0;
      low_lat     <= '0;
      num_lat     <= '0;
      phase_cnt   <= '0;
      pulse_out   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pulses_sent <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            high_lat    <= high_len;
            low_lat     <= (low_len == '0) ? WIDTH'(1) : low_len;
            num_lat     <= num_pulses;
            phase_cnt   <= high_len;
            pulses_sent <= COUNT_WIDTH'(1);
            pulse_out   <= 1'b1;
            busy        <= 1'b1;
            state       <= HIGH;
          end
        end
        HIGH: begin
          if (abort) begin
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (phase_end) begin
            pulse_out <= 1'b0;
            if (pulses_sent == num_lat) begin
              // last pulse: no trailing low phase
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              phase_cnt <= low_lat;
              state     <= LOW;
            end
          end else begin
            phase_cnt <= phase_cnt - WIDTH'(1);
          end
        end
        LOW: begin
          if (abort) begin
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (phase_end) begin
            phase_cnt   <= high_lat;
            pulse_out   <= 1'b1;
            pulses_sent <= pulses_sent + COUNT_WIDTH'(1);
            state       <= HIGH;
          end else begin
            phase_cnt <= phase_cnt - WIDTH'(1);
          end
        end
        default: begin
          pulse_out <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_gen.sv
// Scoreboard bench for pulse_gen: expected per-cycle outputs are queued when a
// train is started and compared every cycle against an 8-bit and a 4-bit instance.
module tb_pulse_gen;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] high_len;
  logic [7:0] low_len;
  logic [7:0] num_pulses;
  logic [3:0] high_len4;
  logic [3:0] low_len4;
  logic       pulse_out, busy, done;
  logic [7:0] pulses_sent;
  logic       pulse_out4, busy4, done4;
  logic [7:0] pulses_sent4;

  assign high_len4 = high_len[3:0];
  assign low_len4  = low_len[3:0];

  always #5 clock = ~clock;

  pulse_gen #(.WIDTH(8), .COUNT_WIDTH(8)) u_dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .high_len(high_len), .low_len(low_len), .num_pulses(num_pulses),
    .pulse_out(pulse_out), .busy(busy), .done(done), .pulses_sent(pulses_sent)
  );

  // narrow instance; every stimulus below keeps phase lengths within 4 bits
  pulse_gen #(.WIDTH(4), .COUNT_WIDTH(8)) u_dut4 (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .high_len(high_len4), .low_len(low_len4), .num_pulses(num_pulses),
    .pulse_out(pulse_out4), .busy(busy4), .done(done4), .pulses_sent(pulses_sent4)
  );

  typedef struct packed {
    logic       p;
    logic       b;
    logic       d;
    logic [7:0] ps;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         edges;
  logic       prev_p;
  logic [7:0] last_ps;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // advance one cycle, release strobes, compare both instances with the queue head
  task automatic step_check();
    exp_t e;
    @(posedge clock);
    #1;
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'(1), 32'(0));
    end else begin
      e = sb.pop_front();
      check("pulse_out",      32'(pulse_out),    32'(e.p));
      check("busy",           32'(busy),         32'(e.b));
      check("done",           32'(done),         32'(e.d));
      check("pulses_sent",    32'(pulses_sent),  32'(e.ps));
      check("pulse_out_w4",   32'(pulse_out4),   32'(e.p));
      check("busy_w4",        32'(busy4),        32'(e.b));
      check("done_w4",        32'(done4),        32'(e.d));
      check("pulses_sent_w4", 32'(pulses_sent4), 32'(e.ps));
      last_ps = e.ps;
    end
    if (pulse_out && !prev_p) edges++;
    prev_p = pulse_out;
  endtask

  task automatic idle(input int k);
    repeat (k) sb.push_back({3'b000, last_ps});
    repeat (k) step_check();
  endtask

  // cut >= 0: abort (or reset) driven during that train cycle
  // ign_idx >= 0: a conflicting start driven during that train cycle
  task automatic run(input logic [7:0] h, input logic [7:0] l, input logic [7:0] n,
                     input int cut, input bit by_reset, input int ign_idx,
                     input bit with_abort);
    bit         ok;
    logic [7:0] lg;
    ok = (h != 8'd0) && (n != 8'd0) && !with_abort;
    lg = (l == 8'd0) ? 8'd1 : l;
    high_len   = h;
    low_len    = l;
    num_pulses = n;
    start      = 1'b1;
    abort      = with_abort;
    sb.delete();
    edges = 0;
    if (ok) begin
      for (int k = 1; k <= int'(n); k++) begin
        repeat (h) sb.push_back({1'b1, 1'b1, 1'b0, 8'(k)});
        if (k < int'(n)) repeat (lg) sb.push_back({1'b0, 1'b1, 1'b0, 8'(k)});
      end
      sb.push_back({1'b0, 1'b0, 1'b1, n});
    end else begin
      repeat (3) sb.push_back({3'b000, last_ps});
    end
    for (int i = 0; sb.size() > 0; i++) begin
      step_check();
      if (i == ign_idx) begin
        high_len   = 8'd1;
        low_len    = 8'd1;
        num_pulses = 8'd1;
        start      = 1'b1;
      end
      if (i == cut) begin
        sb.delete();
        if (by_reset) begin
          reset = 1'b1;
          sb.push_back({3'b000, 8'd0});
        end else begin
          abort = 1'b1;
          sb.push_back({3'b000, last_ps});
        end
      end
    end
    if (ok && cut < 0) check("edge_count", 32'(edges), 32'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    high_len   = 8'd0;
    low_len    = 8'd0;
    num_pulses = 8'd0;
    prev_p     = 1'b0;
    last_ps    = 8'd0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_pulse_out",   32'(pulse_out),   32'(0));
    check("reset_busy",        32'(busy),        32'(0));
    check("reset_done",        32'(done),        32'(0));
    check("reset_pulses_sent", 32'(pulses_sent), 32'(0));
    idle(2);

    // basic train, then a back-to-back start in the done cycle
    run(8'd3, 8'd2, 8'd4, -1, 1'b0, -1, 1'b0);
    run(8'd2, 8'd1, 8'd2, -1, 1'b0, -1, 1'b0);
    idle(2);

    // zero low length behaves as one
    run(8'd1, 8'd0, 8'd3, -1, 1'b0, -1, 1'b0);
    idle(2);

    // rejected starts: zero high length, zero count, abort alongside start
    run(8'd0, 8'd3, 8'd2, -1, 1'b0, -1, 1'b0);
    run(8'd3, 8'd3, 8'd0, -1, 1'b0, -1, 1'b0);
    run(8'd3, 8'd2, 8'd2, -1, 1'b0, -1, 1'b1);

    // abort on the second cycle of the third low phase, stray start in first pulse
    run(8'd5, 8'd5, 8'd10, 26, 1'b0, 3, 1'b0);
    idle(3);

    // widest phase lengths for the 4-bit instance
    run(8'd15, 8'd15, 8'd2, -1, 1'b0, -1, 1'b0);
    idle(2);

    // reset in the middle of a train
    run(8'd2, 8'd1, 8'd3, 4, 1'b1, -1, 1'b0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
